// File: rtl/universal_shift_register_if.sv
// Bundles the control, data and status signals of the universal shift register.
// The master side drives the controls and data; the slave side is the register.
interface universal_shift_register_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] par_in;
  logic             shift_in_lsb;
  logic             shift_in_msb;
  logic [WIDTH-1:0] out;
  logic             serial_out_msb;
  logic             serial_out_lsb;
  logic [CNT_W-1:0] shift_cnt;
  logic             done;

  modport master (
    output en, mode, par_in, shift_in_lsb, shift_in_msb,
    input  out, serial_out_msb, serial_out_lsb, shift_cnt, done
  );

  modport slave (
    input  en, mode, par_in, shift_in_lsb, shift_in_msb,
    output out, serial_out_msb, serial_out_lsb, shift_cnt, done
  );
endinterface

// File: rtl/universal_shift_register.sv
// Universal shift register: load, shift, rotate, arithmetic shift and clear,
// with a saturating shift counter and a one-cycle done pulse on reaching WIDTH shifts.
module universal_shift_register #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic                       clk,
  input logic                       rst,
  universal_shift_register_if.slave bus
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_next;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_next;
  logic             done_q;
  logic             done_next;
  logic             is_shift;

  always_comb begin
    data_next = data_q;
    is_shift  = 1'b0;
    case (bus.mode)
      MODE_HOLD: ;
      MODE_LOAD: data_next = bus.par_in;
      MODE_SHL: begin
        data_next = {data_q[WIDTH-2:0], bus.shift_in_lsb};
        is_shift  = 1'b1;
      end
      MODE_SHR: begin
        data_next = {bus.shift_in_msb, data_q[WIDTH-1:1]};
        is_shift  = 1'b1;
      end
      MODE_ROL: begin
        data_next = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
        is_shift  = 1'b1;
      end
      MODE_ROR: begin
        data_next = {data_q[0], data_q[WIDTH-1:1]};
        is_shift  = 1'b1;
      end
      MODE_ASR: begin
        data_next = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
        is_shift  = 1'b1;
      end
      MODE_CLR: data_next = '0;
      default: ;
    endcase
  end

  // done only fires on the step into saturation, so a saturated counter never re-triggers it
  always_comb begin
    cnt_next  = cnt_q;
    done_next = 1'b0;
    if (bus.mode == MODE_LOAD || bus.mode == MODE_CLR) begin
      cnt_next = '0;
    end else if (is_shift && cnt_q != CNT_MAX) begin
      cnt_next  = cnt_q + CNT_W'(1);
      done_next = (cnt_q == CNT_MAX - CNT_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (bus.en) begin
      data_q <= data_next;
      cnt_q  <= cnt_next;
      done_q <= done_next;
    end else begin
      done_q <= 1'b0;
    end
  end

  assign bus.out            = data_q;
  assign bus.serial_out_msb = data_q[WIDTH-1];
  assign bus.serial_out_lsb = data_q[0];
  assign bus.shift_cnt      = cnt_q;
  assign bus.done           = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register: directed sequences with literal
// expectations, then randomized traffic checked every cycle against an arithmetic model.
module tb_universal_shift_register;

  localparam int W     = 8;
  localparam int CW    = 4;
  localparam int POW   = 1 << W;
  localparam int HALF  = 1 << (W - 1);

  logic clk;
  logic rst;

  universal_shift_register_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  universal_shift_register #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;
  bit check_en = 1'b0;

  int m_out  = 0;
  int m_cnt  = 0;
  int m_done = 0;
  int prev_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: shifts expressed as multiply/divide on an integer value
  always @(posedge clk) begin
    if (rst == 1'b0) begin
      m_out  = 0;
      m_cnt  = 0;
      m_done = 0;
    end else if (bus.en !== 1'b1) begin
      m_done = 0;
    end else begin
      prev_cnt = m_cnt;
      m_done   = 0;
      case (bus.mode)
        3'd0: ;
        3'd1: begin m_out = int'(bus.par_in); m_cnt = 0; end
        3'd7: begin m_out = 0; m_cnt = 0; end
        default: begin
          case (bus.mode)
            3'd2: m_out = (m_out * 2) % POW + int'(bus.shift_in_lsb);
            3'd3: m_out = m_out / 2 + int'(bus.shift_in_msb) * HALF;
            3'd4: m_out = (m_out * 2) % POW + m_out / HALF;
            3'd5: m_out = m_out / 2 + (m_out % 2) * HALF;
            default: m_out = m_out / 2 + ((m_out >= HALF) ? HALF : 0);
          endcase
          m_cnt  = (m_cnt < W) ? m_cnt + 1 : W;
          m_done = (prev_cnt == W - 1 && m_cnt == W) ? 1 : 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      compare("cyc_out",      64'(bus.out),            64'(m_out));
      compare("cyc_cnt",      64'(bus.shift_cnt),      64'(m_cnt));
      compare("cyc_done",     64'(bus.done),           64'(m_done));
      compare("cyc_ser_msb",  64'(bus.serial_out_msb), 64'(m_out / HALF));
      compare("cyc_ser_lsb",  64'(bus.serial_out_lsb), 64'(m_out % 2));
    end
  end

  task automatic applyStimulus(input bit r, input bit e, input logic [2:0] m,
                               input logic [W-1:0] p, input bit lsb, input bit msb);
    rst              = r;
    bus.en           = e;
    bus.mode         = m;
    bus.par_in       = p;
    bus.shift_in_lsb = lsb;
    bus.shift_in_msb = msb;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input int exp_out, input int exp_cnt, input int exp_done);
    compare({name, "_out"},        64'(bus.out),       64'(exp_out));
    compare({name, "_cnt"},        64'(bus.shift_cnt), 64'(exp_cnt));
    compare({name, "_done"},       64'(bus.done),      64'(exp_done));
    compare({name, "_model_out"},  64'(m_out),         64'(exp_out));
    compare({name, "_model_cnt"},  64'(m_cnt),         64'(exp_cnt));
  endtask

  initial begin
    logic [2:0] rm;
    int r;

    // reset holds everything at zero even with a load pending
    applyStimulus(0, 1, 3'b001, 8'hFF, 0, 0);
    check_en = 1'b1;
    applyStimulus(0, 1, 3'b001, 8'hFF, 0, 0);
    checkOutput("reset", 8'h00, 0, 0);

    applyStimulus(1, 1, 3'b001, 8'b10010111, 0, 0);
    checkOutput("load97", 8'b10010111, 0, 0);
    applyStimulus(1, 1, 3'b010, 8'h00, 1, 0);
    applyStimulus(1, 1, 3'b010, 8'h00, 0, 0);
    applyStimulus(1, 1, 3'b010, 8'h00, 1, 0);
    checkOutput("shl3", 8'b10111101, 3, 0);

    applyStimulus(1, 1, 3'b001, 8'b10000001, 0, 0);
    applyStimulus(1, 1, 3'b101, 8'hFF, 1, 1);
    checkOutput("ror1", 8'b11000000, 1, 0);
    applyStimulus(1, 1, 3'b110, 8'h00, 0, 0);
    applyStimulus(1, 1, 3'b110, 8'h00, 0, 0);
    checkOutput("asr2", 8'b11110000, 3, 0);

    applyStimulus(1, 1, 3'b001, 8'hA5, 0, 0);
    for (int i = 0; i < 7; i++) applyStimulus(1, 1, 3'b011, 8'h00, 1, 0);
    checkOutput("shr7", 8'h01, 7, 0);
    applyStimulus(1, 1, 3'b011, 8'h00, 1, 0);
    checkOutput("shr8", 8'h00, 8, 1);
    applyStimulus(1, 1, 3'b011, 8'h00, 1, 0);
    checkOutput("shr9", 8'h00, 8, 0);

    applyStimulus(1, 1, 3'b001, 8'h3C, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 3'b010, 8'h00, 0, 0);
    checkOutput("en_pre", 8'hE0, 3, 0);
    applyStimulus(1, 0, 3'b010, 8'h00, 1, 1);
    applyStimulus(1, 0, 3'b010, 8'h00, 1, 1);
    checkOutput("en_off", 8'hE0, 3, 0);
    applyStimulus(1, 1, 3'b010, 8'h00, 0, 0);
    checkOutput("en_back", 8'hC0, 4, 0);

    applyStimulus(1, 1, 3'b001, 8'h5A, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 3'b010, 8'h00, 1, 0);
    applyStimulus(0, 1, 3'b010, 8'h00, 1, 0);
    checkOutput("mid_rst", 8'h00, 0, 0);
    for (int i = 0; i < 7; i++) applyStimulus(1, 1, 3'b010, 8'h00, 1, 0);
    checkOutput("post_rst", 8'h7F, 7, 0);

    applyStimulus(1, 1, 3'b100, 8'h00, 0, 0);
    checkOutput("rol_sat", 8'hFE, 8, 1);
    applyStimulus(1, 1, 3'b111, 8'hFF, 1, 1);
    checkOutput("clear", 8'h00, 0, 0);

    // randomized traffic, biased toward shift modes so the counter saturates regularly
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 15);
      if (r < 2)       rm = 3'b001;
      else if (r == 2) rm = 3'b111;
      else if (r == 3) rm = 3'b000;
      else             rm = 3'($urandom_range(2, 6));
      applyStimulus(($urandom_range(0, 63) != 0), ($urandom_range(0, 7) != 0), rm,
                    W'($urandom), 1'($urandom), 1'($urandom));
    end

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/universal_shift_register.md
UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 Parameter WIDTH, default 8, meaning register width in bits (legal range 2..64).
REQ-002 Parameter CNT_W, default 4, meaning shift-counter width; SHALL be at least clog2(WIDTH+1).
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock; the only clock.
REQ-005 rst  input  1  synchronous active-low reset.
REQ-006 en  input  1  clock enable; when 0, all state holds.
REQ-007 mode  input  3  operation select, encoding per REQ-012.
REQ-008 par_in  input  WIDTH  parallel load data.
REQ-009 shift_in_lsb  input  1  serial bit entering bit 0 on shift-left.
REQ-010 shift_in_msb  input  1  serial bit entering bit WIDTH-1 on logical shift-right.
REQ-011 out  output  WIDTH  register contents; serial_out_msb = out[WIDTH-1] and serial_out_lsb = out[0] are 1-bit outputs; shift_cnt is a CNT_W-bit output; done is a 1-bit output.

Function
REQ-012 On a rising clk edge with rst=1 and en=1, out SHALL update per mode:
  - 000 hold
  - 001 load par_in
  - 010 shift left {out[W-2:0], shift_in_lsb}
  - 011 logical shift right {shift_in_msb, out[W-1:1]}
  - 100 rotate left
  - 101 rotate right
  - 110 arithmetic shift right {out[W-1], out[W-1:1]}
  - 111 clear to 0.
REQ-013 Latency SHALL be one cycle; out reflects the operation on the edge where it is sampled, with no combinational path from inputs to out.
REQ-014 shift_cnt SHALL reset to 0 on load (001) or clear (111).
REQ-015 shift_cnt SHALL increment by 1 on each shift or rotate mode (010-110), saturating at WIDTH.
REQ-016 shift_cnt SHALL hold on mode 000 or en=0.
REQ-017 done SHALL be a registered one-cycle pulse asserted in the cycle after shift_cnt transitions from WIDTH-1 to WIDTH; it is 0 otherwise.
REQ-018 Once saturated at WIDTH, further shifts SHALL NOT re-assert done until a load or clear has occurred.
REQ-019 With en=0, out and shift_cnt SHALL hold and done SHALL be 0 on the next edge.
REQ-020 par_in, shift_in_lsb and shift_in_msb SHALL be ignored in modes that do not use them.
REQ-021 Mode changes between any two cycles SHALL be legal, with no extra latency or bubble.
REQ-022 serial_out_msb and serial_out_lsb SHALL be continuous assignments from out.

Reset
REQ-023 On a rising clk edge with rst=0, out SHALL become 0, shift_cnt 0 and done 0, regardless of en, mode or data inputs.
REQ-024 Reset asserted mid-sequence SHALL abort the sequence: no done pulse is produced for it, and the counter restarts from 0 after reset release.
REQ-025 The first edge with rst=1 SHALL perform the operation selected by mode normally.

Verification (WIDTH=8)
REQ-026 Hold rst=0 for 2 cycles with mode=001, par_in=8'hFF -> out=8'h00, shift_cnt=0, done=0.
REQ-027 Load 8'b10010111, then shift left with shift_in_lsb=1,0,1 -> out=8'b10111101, shift_cnt=3.
REQ-028 Load 8'b10000001, then rotate right 1 cycle -> out=8'b11000000. Then arithmetic shift right 2 cycles -> out=8'b11110000, shift_cnt=3.
REQ-029 Load 8'hA5, then shift right 8 cycles with shift_in_msb=0 -> out=8'h00, shift_cnt=8, done high for exactly 1 cycle; a 9th shift leaves shift_cnt=8 with done=0.
REQ-030 Load 8'h3C, then shift left 3 cycles, drop en to 0 for 2 cycles while mode=010, then reassert en -> out and shift_cnt frozen while en=0, done=0 throughout.
REQ-031 Shift left 5 cycles after a load, assert rst=0 for 1 cycle, release, then shift 7 cycles -> no done pulse; shift_cnt=7.
